// File: rtl/snake_px_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_px_pkg
// Brief    : Shared types and constants for the snake pixel-buffer responder.
// Revision : 1.0 - initial release
// ============================================================================
package snake_px_pkg;

    localparam int unsigned NUM_X = 320;
    localparam int unsigned NUM_Y = 240;
    localparam int unsigned X_LSB = 1;
    localparam int unsigned Y_LSB = 10;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned LIN_W = 17;

    typedef logic [15:0]      rgb565_t;
    typedef logic [LIN_W-1:0] lin_t;

    typedef struct packed {
        lin_t    lin;
        rgb565_t data;
    } px_fifo_entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } rd_state_t;

    // y*320 + x as two shifts and adds; the full range fits LIN_W bits.
    function automatic lin_t px_lin(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        lin_t y_l;
        y_l = lin_t'(y);
        return (y_l << 8) + (y_l << 6) + lin_t'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_px_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_px_responder_if
// Brief    : Avalon-MM pixel port between the vga_px master and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface snake_px_responder_if;
    import snake_px_pkg::*;

    logic [31:0] px_address;
    logic        px_read;
    logic        px_write;
    rgb565_t     px_writedata;
    logic        px_waitrequest;
    rgb565_t     px_readdata;

    modport master (
        output px_address, px_read, px_write, px_writedata,
        input  px_waitrequest, px_readdata
    );

    modport slave (
        input  px_address, px_read, px_write, px_writedata,
        output px_waitrequest, px_readdata
    );

endinterface
`default_nettype wire

// File: rtl/snake_px_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snake_px_fifo
// Brief    : Synchronous posted-write FIFO with full/empty and same-cycle push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module snake_px_fifo
    import snake_px_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           push,
    input  px_fifo_entry_t      push_data,
    input  wire logic           pop,
    output px_fifo_entry_t      pop_data,
    output logic                full,
    output logic                empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    px_fifo_entry_t storage_q [DEPTH];
    logic           w_do_push;
    logic           w_do_pop;

    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = storage_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            storage_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_px_responder.sv
`default_nettype none
// ============================================================================
// Module   : snake_px_responder
// Brief    : Avalon-MM pixel-buffer stand-in: posted writes into a linear
//            framebuffer, flushed reads. Optional SNAKE_PX_BOUNDS_CHECK_EN
//            drops out-of-range writes and adds the drop_count port.
// Revision : 1.0 - initial release
// ============================================================================
module snake_px_responder
    import snake_px_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_X      = snake_px_pkg::NUM_X,
    parameter int unsigned NUM_Y      = snake_px_pkg::NUM_Y,
    parameter int unsigned MEM_AW     = 17
) (
    input  wire logic                clk,
    input  wire logic                reset,
    snake_px_responder_if.slave      px,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [15:0]              mem_wdata,
    input  wire logic [15:0]         mem_rdata,
    input  wire logic                mem_busy
`ifdef SNAKE_PX_BOUNDS_CHECK_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    logic [X_W-1:0]   w_px_x;
    logic [Y_W-1:0]   w_px_y;
    lin_t             w_req_lin;
    logic             w_coord_ok;
    logic             w_push_ok;
    logic             w_rd_oob;
    logic             w_rd_req;
    logic             w_rd_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    px_fifo_entry_t   w_push_entry;
    px_fifo_entry_t   w_pop_entry;

    rd_state_t        rd_state_q;
    logic             rd_lat_q;
    rgb565_t          px_readdata_q;

    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    rgb565_t           mem_wdata_q, mem_wdata_d;

    logic unused_addr;

    assign w_px_x    = px.px_address[X_LSB +: X_W];
    assign w_px_y    = px.px_address[Y_LSB +: Y_W];
    assign w_req_lin = px_lin(w_px_x, w_px_y);
    assign w_coord_ok = (32'(w_px_x) < NUM_X) && (32'(w_px_y) < NUM_Y);
    assign unused_addr = ^{px.px_address[31:Y_LSB+Y_W], px.px_address[X_LSB-1:0]};

`ifdef SNAKE_PX_BOUNDS_CHECK_EN
    logic [15:0] drop_count_q, drop_count_d;

    assign w_push_ok = w_coord_ok;
    assign w_rd_oob  = ~w_coord_ok;

    always_comb begin
        drop_count_d = drop_count_q;
        if (px.px_write && !w_coord_ok && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    logic unused_coord_ok;

    assign w_push_ok       = 1'b1;
    assign w_rd_oob        = 1'b0;
    assign unused_coord_ok = w_coord_ok;
`endif

    assign w_rd_req     = px.px_read & ~px.px_write;
    assign w_push       = px.px_write & w_push_ok;
    assign w_pop        = ~mem_busy & ~w_empty;
    assign w_push_entry = '{lin: w_req_lin, data: px.px_writedata};
    assign w_rd_issue   = (rd_state_q == ISSUE) & w_rd_req & ~mem_busy;

    snake_px_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Writes stall only on a full FIFO (sampled before this cycle's pop);
    // reads stall every cycle except the single DONE acknowledge.
    always_comb begin
        if (reset) begin
            px.px_waitrequest = 1'b1;
        end else if (px.px_write) begin
            px.px_waitrequest = w_full & w_push_ok;
        end else begin
            px.px_waitrequest = (rd_state_q != DONE);
        end
    end

    assign px.px_readdata = px_readdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= IDLE;
            rd_lat_q      <= 1'b0;
            px_readdata_q <= '0;
        end else begin
            case (rd_state_q)
                IDLE: begin
                    if (w_rd_req) begin
                        if (w_rd_oob) begin
                            px_readdata_q <= '0;
                            rd_state_q    <= DONE;
                        end else begin
                            rd_state_q    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!w_rd_req) begin
                        rd_state_q <= IDLE;
                    end else if (w_empty) begin
                        rd_state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!w_rd_req) begin
                        rd_state_q <= IDLE;
                    end else if (!mem_busy) begin
                        rd_lat_q   <= 1'b0;
                        rd_state_q <= WAIT;
                    end
                end
                // First WAIT cycle presents the address; read data lands on the second.
                WAIT: begin
                    if (!w_rd_req) begin
                        rd_state_q <= IDLE;
                    end else if (rd_lat_q) begin
                        px_readdata_q <= mem_rdata;
                        rd_state_q    <= DONE;
                    end else begin
                        rd_lat_q <= 1'b1;
                    end
                end
                DONE: begin
                    rd_state_q <= IDLE;
                end
                default: begin
                    rd_state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_we_d    = w_pop;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (w_pop) begin
            mem_addr_d  = MEM_AW'(w_pop_entry.lin);
            mem_wdata_d = w_pop_entry.data;
        end else if (w_rd_issue) begin
            mem_addr_d  = MEM_AW'(w_req_lin);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
